// File: rtl/ac_seq_ctrl.sv
// rtl/ac_seq_ctrl.sv - quadrant sequencer building an approximate 8x8 product from a shared 4x4 multiplier
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     request handshake; in_a, in_b operands, in_exact forces exact mode
//   pp_a, pp_b, pp_sel    nibble operands and mode driven to the external 4x4 multiplier
//   pp_prod               combinational 4x4 product returned in the same cycle
//   out_valid/out_ready   result handshake; out_prod holds the accumulated product
//   busy                  high whenever the sequencer is not idle
module ac_seq_ctrl #(
  parameter int ZERO_SKIP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic        in_exact,
  output logic [3:0]  pp_a,
  output logic [3:0]  pp_b,
  output logic [1:0]  pp_sel,
  input  logic [7:0]  pp_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_prod,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LL   = 3'd1,
    LH   = 3'd2,
    HL   = 3'd3,
    HH   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state, state_next;
  logic [7:0]  a_r, b_r;
  logic        exact_r;
  logic [15:0] acc;
  logic [15:0] addend;
  logic [3:0]  need_in, need_r;

  // Bit i set means quadrant i (LL, LH, HL, HH) has to be computed.
  function automatic logic [3:0] need_mask(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] m;
    m[0] = (ZERO_SKIP == 0) || ((a[3:0] != 4'd0) && (b[3:0] != 4'd0));
    m[1] = (ZERO_SKIP == 0) || ((a[3:0] != 4'd0) && (b[7:4] != 4'd0));
    m[2] = (ZERO_SKIP == 0) || ((a[7:4] != 4'd0) && (b[3:0] != 4'd0));
    m[3] = (ZERO_SKIP == 0) || ((a[7:4] != 4'd0) && (b[7:4] != 4'd0));
    return m;
  endfunction

  function automatic state_t first_of(input logic [3:0] m);
    if (m[0])      return LL;
    else if (m[1]) return LH;
    else if (m[2]) return HL;
    else if (m[3]) return HH;
    else           return DONE;
  endfunction

  assign need_in   = need_mask(in_a, in_b);
  assign need_r    = need_mask(a_r, b_r);
  // Gated by rst so no handshake is ever advertised while reset is applied.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_prod  = acc;

  always_comb begin
    state_next = state;
    pp_a       = 4'd0;
    pp_b       = 4'd0;
    pp_sel     = 2'd0;
    addend     = 16'd0;
    case (state)
      IDLE: begin
        if (in_valid) state_next = first_of(need_in);
      end
      LL: begin
        pp_a       = a_r[3:0];
        pp_b       = b_r[3:0];
        pp_sel     = exact_r ? 2'd0 : 2'd3;
        addend     = {8'd0, pp_prod};
        state_next = first_of(need_r & 4'b1110);
      end
      LH: begin
        pp_a       = a_r[3:0];
        pp_b       = b_r[7:4];
        pp_sel     = exact_r ? 2'd0 : 2'd2;
        addend     = {4'd0, pp_prod, 4'd0};
        state_next = first_of(need_r & 4'b1100);
      end
      HL: begin
        pp_a       = a_r[7:4];
        pp_b       = b_r[3:0];
        pp_sel     = exact_r ? 2'd0 : 2'd2;
        addend     = {4'd0, pp_prod, 4'd0};
        state_next = first_of(need_r & 4'b1000);
      end
      HH: begin
        pp_a       = a_r[7:4];
        pp_b       = b_r[7:4];
        pp_sel     = exact_r ? 2'd0 : 2'd1;
        addend     = {pp_prod, 8'd0};
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= 16'd0;
      a_r     <= 8'd0;
      b_r     <= 8'd0;
      exact_r <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && in_valid) begin
        a_r     <= in_a;
        b_r     <= in_b;
        exact_r <= in_exact;
        acc     <= 16'd0;
      end else begin
        // addend is zero outside the quadrant states; wraps modulo 2^16.
        acc <= acc + addend;
      end
    end
  end

endmodule

// File: tb/tb_ac_seq_ctrl.sv
// tb/tb_ac_seq_ctrl.sv - directed self-checking bench for ac_seq_ctrl
module tb_ac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_a = 8'd0;
  logic [7:0]  in_b = 8'd0;
  logic        in_exact = 1'b0;

  // dut1: ZERO_SKIP = 1 with exact multiplier model
  logic        in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic        in_ready1, out_valid1, busy1;
  logic [3:0]  pp_a1, pp_b1;
  logic [1:0]  pp_sel1;
  logic [7:0]  pp_prod1;
  logic [15:0] out_prod1;

  // dut0: ZERO_SKIP = 0, multiplier model switchable to constant 0xFF
  logic        in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic        in_ready0, out_valid0, busy0;
  logic [3:0]  pp_a0, pp_b0;
  logic [1:0]  pp_sel0;
  logic [7:0]  pp_prod0;
  logic [15:0] out_prod0;
  logic        ovf_mode = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign pp_prod1 = {4'd0, pp_a1} * {4'd0, pp_b1};
  assign pp_prod0 = ovf_mode ? 8'hFF : ({4'd0, pp_a0} * {4'd0, pp_b0});

  ac_seq_ctrl #(.ZERO_SKIP(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_exact(in_exact),
    .pp_a(pp_a1), .pp_b(pp_b1), .pp_sel(pp_sel1), .pp_prod(pp_prod1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_prod(out_prod1), .busy(busy1)
  );

  ac_seq_ctrl #(.ZERO_SKIP(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_exact(in_exact),
    .pp_a(pp_a0), .pp_b(pp_b0), .pp_sel(pp_sel0), .pp_prod(pp_prod0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_prod(out_prod0), .busy(busy0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept1(input logic [7:0] a, input logic [7:0] b, input logic ex);
    in_a = a; in_b = b; in_exact = ex; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
  endtask

  task automatic drain1();
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++; if (in_ready1 !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready1); end
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy1); end
    vectors++; if (out_valid1 !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid1); end
    vectors++; if ({pp_a1, pp_b1, pp_sel1} !== 10'd0) begin miscompares++; $display("FAIL reset_pp got %h want 0", {pp_a1, pp_b1, pp_sel1}); end
    rst = 1'b0;
    #1;
    vectors++; if (in_ready1 !== 1'b1) begin miscompares++; $display("FAIL release_in_ready got %b want 1", in_ready1); end
    vectors++; if (in_ready0 !== 1'b1) begin miscompares++; $display("FAIL release_in_ready0 got %b want 1", in_ready0); end
  endtask

  task automatic test_exact_ff();
    accept1(8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      vectors++; if (out_valid1 !== 1'b0) begin miscompares++; $display("FAIL ff_early_valid q%0d got %b want 0", i, out_valid1); end
      vectors++; if ({pp_a1, pp_b1, pp_sel1} !== {4'hF, 4'hF, 2'd0}) begin miscompares++; $display("FAIL ff_pp q%0d got %h want %h", i, {pp_a1, pp_b1, pp_sel1}, {4'hF, 4'hF, 2'd0}); end
      vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL ff_busy q%0d got %b want 1", i, busy1); end
      step();
    end
    vectors++; if (out_valid1 !== 1'b1) begin miscompares++; $display("FAIL ff_valid got %b want 1", out_valid1); end
    vectors++; if (out_prod1 !== 16'hFE01) begin miscompares++; $display("FAIL ff_prod got %h want fe01", out_prod1); end
    vectors++; if ({pp_a1, pp_b1, pp_sel1} !== 10'd0) begin miscompares++; $display("FAIL ff_done_pp got %h want 0", {pp_a1, pp_b1, pp_sel1}); end
    drain1();
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL ff_idle got busy %b want 0", busy1); end
  endtask

  task automatic test_ll_only();
    accept1(8'h0F, 8'h0F, 1'b0);
    vectors++; if ({pp_a1, pp_b1, pp_sel1} !== {4'hF, 4'hF, 2'd3}) begin miscompares++; $display("FAIL ll_pp got %h want %h", {pp_a1, pp_b1, pp_sel1}, {4'hF, 4'hF, 2'd3}); end
    vectors++; if (out_valid1 !== 1'b0) begin miscompares++; $display("FAIL ll_early_valid got %b want 0", out_valid1); end
    step();
    vectors++; if (out_valid1 !== 1'b1) begin miscompares++; $display("FAIL ll_valid got %b want 1", out_valid1); end
    vectors++; if (out_prod1 !== 16'h00E1) begin miscompares++; $display("FAIL ll_prod got %h want 00e1", out_prod1); end
    drain1();
  endtask

  task automatic test_zero();
    accept1(8'h00, 8'h5A, 1'b0);
    vectors++; if (out_valid1 !== 1'b1) begin miscompares++; $display("FAIL zero_valid got %b want 1", out_valid1); end
    vectors++; if (out_prod1 !== 16'h0000) begin miscompares++; $display("FAIL zero_prod got %h want 0000", out_prod1); end
    vectors++; if ({pp_a1, pp_b1, pp_sel1} !== 10'd0) begin miscompares++; $display("FAIL zero_pp got %h want 0", {pp_a1, pp_b1, pp_sel1}); end
    drain1();
  endtask

  task automatic test_mixed();
    logic [9:0] exp_pp [4];
    exp_pp[0] = {4'h2, 4'h4, 2'd3};
    exp_pp[1] = {4'h2, 4'h3, 2'd2};
    exp_pp[2] = {4'h1, 4'h4, 2'd2};
    exp_pp[3] = {4'h1, 4'h3, 2'd1};
    accept1(8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 4; i++) begin
      vectors++; if ({pp_a1, pp_b1, pp_sel1} !== exp_pp[i]) begin miscompares++; $display("FAIL mixed_pp q%0d got %h want %h", i, {pp_a1, pp_b1, pp_sel1}, exp_pp[i]); end
      step();
    end
    vectors++; if (out_valid1 !== 1'b1) begin miscompares++; $display("FAIL mixed_valid got %b want 1", out_valid1); end
    vectors++; if (out_prod1 !== 16'h03A8) begin miscompares++; $display("FAIL mixed_prod got %h want 03a8", out_prod1); end
    drain1();
  endtask

  task automatic test_backpressure();
    accept1(8'h0F, 8'h0F, 1'b1);
    vectors++; if (pp_sel1 !== 2'd0) begin miscompares++; $display("FAIL bp_sel got %0d want 0", pp_sel1); end
    step();
    in_a = 8'hAA; in_b = 8'h55; in_exact = 1'b0; in_valid1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (out_valid1 !== 1'b1) begin miscompares++; $display("FAIL bp_valid c%0d got %b want 1", i, out_valid1); end
      vectors++; if (out_prod1 !== 16'h00E1) begin miscompares++; $display("FAIL bp_prod c%0d got %h want 00e1", i, out_prod1); end
      vectors++; if (in_ready1 !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready c%0d got %b want 0", i, in_ready1); end
      step();
    end
    out_ready1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    out_ready1 = 1'b0;
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL bp_idle got busy %b want 0", busy1); end
    vectors++; if (out_valid1 !== 1'b0) begin miscompares++; $display("FAIL bp_release got %b want 0", out_valid1); end
    vectors++; if (in_ready1 !== 1'b1) begin miscompares++; $display("FAIL bp_ready_after got %b want 1", in_ready1); end
  endtask

  task automatic test_overflow();
    ovf_mode = 1'b1;
    in_a = 8'h11; in_b = 8'h11; in_exact = 1'b0; in_valid0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL ovf_early_valid q%0d got %b want 0", i, out_valid0); end
      step();
    end
    vectors++; if (out_valid0 !== 1'b1) begin miscompares++; $display("FAIL ovf_valid got %b want 1", out_valid0); end
    vectors++; if (out_prod0 !== 16'h1FDF) begin miscompares++; $display("FAIL ovf_prod got %h want 1fdf", out_prod0); end
    out_ready0 = 1'b1;
    step();
    out_ready0 = 1'b0;
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL ovf_idle got busy %b want 0", busy0); end
  endtask

  task automatic test_reset_mid();
    accept1(8'h12, 8'h34, 1'b1);
    step();
    step();
    vectors++; if ({pp_a1, pp_b1} !== {4'h1, 4'h4}) begin miscompares++; $display("FAIL mid_hl_pp got %h want 14", {pp_a1, pp_b1}); end
    rst = 1'b1;
    vectors++; if (in_ready1 !== 1'b0) begin miscompares++; $display("FAIL mid_ready_rst got %b want 0", in_ready1); end
    step();
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL mid_idle got busy %b want 0", busy1); end
    vectors++; if (in_ready1 !== 1'b0) begin miscompares++; $display("FAIL mid_ready_hi got %b want 0", in_ready1); end
    vectors++; if ({pp_a1, pp_b1, pp_sel1} !== 10'd0) begin miscompares++; $display("FAIL mid_pp got %h want 0", {pp_a1, pp_b1, pp_sel1}); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (out_valid1 !== 1'b0) begin miscompares++; $display("FAIL mid_no_valid c%0d got %b want 0", i, out_valid1); end
      step();
    end
    vectors++; if (in_ready1 !== 1'b1) begin miscompares++; $display("FAIL mid_ready_after got %b want 1", in_ready1); end
  endtask

  initial begin
    test_reset();
    test_exact_ff();
    test_ll_only();
    test_zero();
    test_mixed();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ac_seq_ctrl.md
AC_SEQ_CTRL -- requirements
Module: ac_seq_ctrl

Interface
REQ-001 Parameter ZERO_SKIP, default 1: 1 means a quadrant with a zero operand nibble is skipped; 0 means all four quadrants are always computed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request carries valid operands.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 in_a, in_b  input  8 each  unsigned multiplicand and multiplier.
REQ-007 in_exact  input  1  force the exact 4x4 mode for every quadrant of this request.
REQ-008 pp_a, pp_b  output  4 each  nibble operands driven to the shared external 4x4 multiplier.
REQ-009 pp_sel  output  2  multiplier mode: 0 exact, 1 ap1, 2 ap2, 3 ap3.
REQ-010 pp_prod  input  8  combinational 4x4 product returned in the same cycle.
REQ-011 out_valid  output  1  out_prod holds a completed result.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_prod  output  16  accumulated approximate 8x8 product.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement the states IDLE, LL, LH, HL, HH and DONE, one-hot or encoded.
REQ-016 in_ready SHALL be 1 only in IDLE; a request is accepted on an edge where in_valid and in_ready are both 1.
REQ-017 On acceptance, the block SHALL perform all of the following:
- capture in_a, in_b and in_exact;
- clear the accumulator to 0;
- go to the first non-skipped quadrant in the order LL, LH, HL, HH, or directly to DONE if none remain.
REQ-018 The quadrant operands SHALL be:
- LL: pp_a = a[3:0], pp_b = b[3:0];
- LH: pp_a = a[3:0], pp_b = b[7:4];
- HL: pp_a = a[7:4], pp_b = b[3:0];
- HH: pp_a = a[7:4], pp_b = b[7:4].
REQ-019 pp_sel SHALL be 0 in every quadrant when the captured in_exact is 1; otherwise HH = 1, LH and HL = 2, LL = 3.
REQ-020 In each quadrant state (exactly one cycle), the accumulator SHALL add pp_prod shifted as follows: LL by 0, LH and HL by 4, HH by 8.
REQ-021 The add is performed modulo 2^16, so carries above bit 15 are discarded.
REQ-022 With ZERO_SKIP = 1, a quadrant whose pp_a or pp_b nibble is 0 SHALL be skipped; it contributes 0 and consumes no cycle.
REQ-023 Latency: out_valid SHALL rise N edges after the acceptance edge, where N is the number of computed quadrants (0..4).
- N = 0 means out_valid is high in the cycle immediately after acceptance.
REQ-024 In DONE, the block SHALL hold out_valid = 1 and out_prod stable until an edge with out_ready = 1, then return to IDLE.
- No new request is accepted on that edge.
REQ-025 Changes to in_a, in_b or in_exact after acceptance SHALL NOT affect the request in flight.
REQ-026 Outside the quadrant states, pp_a, pp_b and pp_sel SHALL be 0.
REQ-027 out_prod SHALL equal the accumulator register and SHALL be meaningful only while out_valid = 1.
REQ-028 Minimum occupancy per request SHALL be N + 1 cycles (compute plus the DONE handshake).

Reset
REQ-029 While rst = 1 at an edge, the block SHALL take its reset values: state IDLE, accumulator 0, out_valid 0, busy 0, pp_a 0, pp_b 0, pp_sel 0.
REQ-030 in_ready SHALL be 0 during any cycle in which rst is sampled high, and 1 in the first cycle after reset is released.
REQ-031 Reset asserted mid-operation (any quadrant or DONE) SHALL abandon the request with no out_valid pulse.

Verification
REQ-032 The bench SHALL cover these directed scenarios, using an exact 4x4 model on pp_prod:
- a = 0xFF, b = 0xFF, in_exact = 1, ZERO_SKIP = 1 -> states LL, LH, HL, HH; pp_sel = 0 throughout; out_valid at accept + 4; out_prod = 0xFE01.
- a = 0x0F, b = 0x0F -> only LL computed; pp_sel = 3; out_valid at accept + 1; out_prod = 0x00E1.
- a = 0x00, b = 0x5A -> IDLE goes straight to DONE; out_valid in the next cycle; out_prod = 0x0000.
- a = 0x12, b = 0x34, in_exact = 0 -> pp_sel sequence 3, 2, 2, 1; with an exact model, out_prod = 0x03A8.
- Backpressure: out_ready held 0 for 5 cycles -> out_valid and out_prod stay stable; in_ready stays 0; in_a changed meanwhile has no effect; IDLE is reached 1 edge after out_ready rises.
- Overflow: a model returning pp_prod = 0xFF always, ZERO_SKIP = 0, a = b = 0x11 -> out_prod = 0x1FDF (73695 mod 65536).
- rst pulsed during the HL state -> next cycle IDLE with in_ready = 0 while rst is high, and no out_valid.
